// File: rtl/pipelined_addsub_pkg.sv
// Shared constants and sizing helpers for the pipelined add/subtract unit.
package addsub_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction
endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result bundle for pipelined_addsub; ovf exists only when ADDSUB_OVF_EN is defined.
interface pipelined_addsub_if #(parameter int WIDTH = 32);
  // valid/ready: a transfer occurs on any cycle where valid and ready are both
  // high; the producer keeps valid and its payload stable until that cycle.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDSUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout
`ifdef ADDSUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout
`ifdef ADDSUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/pipelined_addsub_chunk_adder.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB for overflow.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_msb_cin
);
  logic [CHUNK:0] w_full;

  assign w_full    = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
  assign o_sum     = w_full[CHUNK-1:0];
  assign o_cout    = w_full[CHUNK];
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
  assign o_msb_cin = w_full[CHUNK-1] ^ i_a[CHUNK-1] ^ i_b[CHUNK-1];
endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: WIDTH is resolved CHUNK bits per stage, carry registered between stages.
// Define ADDSUB_OVF_EN to add a registered signed-overflow output aligned with sum.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic               clk,
  input logic               rst,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (!width_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  logic [WIDTH-1:0] w_a_in   [STAGES];
  logic [WIDTH-1:0] w_b_in   [STAGES];
  logic [WIDTH-1:0] w_sum_in [STAGES];
  logic [WIDTH-1:0] w_sum_nxt[STAGES];
  logic [CHUNK-1:0] w_slice  [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_cout;
  logic [STAGES-1:0] w_msb_cin;

  logic [WIDTH-1:0]  r_a  [STAGES];
  logic [WIDTH-1:0]  r_b  [STAGES];
  logic [WIDTH-1:0]  r_sum[STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_vld;

  // The whole pipe advances or freezes together; no bubble collapsing.
  assign w_en         = !r_vld[STAGES-1] || bus.out_ready;
  assign bus.in_ready = w_en;

  // Subtraction runs as A + ~B + ~borrow, so cout=1 means no borrow.
  assign w_b_eff = (bus.sub == MODE_ADD) ? bus.b : ~bus.b;
  assign w_c0    = bus.cin ^ (bus.sub == MODE_SUB);

  // Stage s sees operands right-aligned so its slice is always the low CHUNK bits.
  always_comb begin
    w_a_in[0]   = bus.a;
    w_b_in[0]   = w_b_eff;
    w_c_in[0]   = w_c0;
    w_sum_in[0] = '0;
    for (int s = 1; s < STAGES; s++) begin
      w_a_in[s]   = r_a[s-1];
      w_b_in[s]   = r_b[s-1];
      w_c_in[s]   = r_c[s-1];
      w_sum_in[s] = r_sum[s-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .i_a      (w_a_in[g][CHUNK-1:0]),
      .i_b      (w_b_in[g][CHUNK-1:0]),
      .i_cin    (w_c_in[g]),
      .o_sum    (w_slice[g]),
      .o_cout   (w_cout[g]),
      .o_msb_cin(w_msb_cin[g])
    );
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      w_sum_nxt[s] = w_sum_in[s];
      w_sum_nxt[s][s*CHUNK +: CHUNK] = w_slice[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '{default: '0};
      r_b   <= '{default: '0};
      r_sum <= '{default: '0};
      r_c   <= '0;
      r_vld <= '0;
    end else if (w_en) begin
      r_vld[0] <= bus.in_valid;
      for (int s = 1; s < STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
      for (int s = 0; s < STAGES; s++) begin
        r_a[s]   <= w_a_in[s] >> CHUNK;
        r_b[s]   <= w_b_in[s] >> CHUNK;
        r_c[s]   <= w_cout[s];
        r_sum[s] <= w_sum_nxt[s];
      end
    end
  end

  // Last-stage operand remainders and non-MSB slice carries have no consumer.
  logic w_unused_tail;
  assign w_unused_tail = ^{r_a[STAGES-1], r_b[STAGES-1], w_msb_cin};

  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.sum       = r_sum[STAGES-1];
  assign bus.cout      = r_c[STAGES-1];

`ifdef ADDSUB_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_en) begin
      r_ovf <= w_msb_cin[STAGES-1] ^ w_cout[STAGES-1];
    end
  end

  assign bus.ovf = r_ovf;
`endif
endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub (WIDTH=32, CHUNK=8, latency 4); ovf checks need ADDSUB_OVF_EN.
module tb_pipelined_addsub;
  localparam int WIDTH = 32;
  localparam int LAT   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_addsub #(.WIDTH(WIDTH), .CHUNK(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    bus.sub      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.sum !== 32'h0) begin failures++; $display("FAIL reset_sum got=%h exp=00000000", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin failures++; $display("FAIL reset_cout got=%0b exp=0", bus.cout); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
`ifdef ADDSUB_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf); end
`endif
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_add_carry();
    drive_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    drive_idle();
    for (int c = 1; c < LAT; c++) begin
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid cycle=%0d got=%0b exp=0", c, bus.out_valid); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.sum !== 32'hFFFF_FFFF) begin failures++; $display("FAIL add_sum got=%h exp=ffffffff", bus.sum); end
    checks++; if (bus.cout !== 1'b1) begin failures++; $display("FAIL add_cout got=%0b exp=1", bus.cout); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_single_valid got=%0b exp=0", bus.out_valid); end
  endtask

  // Subtractions issued every other cycle, so each is followed by a bubble.
  task automatic test_sub_bubbles();
    logic [31:0] va[3], vb[3], es[3];
    logic        vc[3], ec[3];
    int          k;
    va = '{32'd5, 32'd7, 32'd10};
    vb = '{32'd7, 32'd5, 32'd3};
    vc = '{1'b0, 1'b0, 1'b1};
    es = '{32'hFFFF_FFFE, 32'd2, 32'd6};
    ec = '{1'b0, 1'b1, 1'b1};
    for (int c = 0; c < 11; c++) begin
      if ((c % 2 == 0) && (c / 2 < 3)) drive_op(va[c/2], vb[c/2], vc[c/2], 1'b1);
      else drive_idle();
      #1;
      k = c - LAT;
      if (k >= 0 && (k % 2 == 0) && (k / 2 < 3)) begin
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL sub_valid op=%0d got=%0b exp=1", k/2, bus.out_valid); end
        checks++; if (bus.sum !== es[k/2]) begin failures++; $display("FAIL sub_sum op=%0d got=%h exp=%h", k/2, bus.sum, es[k/2]); end
        checks++; if (bus.cout !== ec[k/2]) begin failures++; $display("FAIL sub_cout op=%0d got=%0b exp=%0b", k/2, bus.cout, ec[k/2]); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL sub_bubble cycle=%0d got=%0b exp=0", c, bus.out_valid); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[4], es[4];
    logic        ec[4];
    va = '{32'h1, 32'hFF, 32'hFFFF, 32'hFFFF_FFFF};
    es = '{32'h2, 32'h100, 32'h1_0000, 32'h0};
    ec = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 10; c++) begin
      if (c < 4) drive_op(va[c], 32'h1, 1'b0, 1'b0);
      else drive_idle();
      #1;
      if (c >= LAT && c < LAT + 4) begin
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid op=%0d got=%0b exp=1", c-LAT, bus.out_valid); end
        checks++; if (bus.sum !== es[c-LAT]) begin failures++; $display("FAIL stream_sum op=%0d got=%h exp=%h", c-LAT, bus.sum, es[c-LAT]); end
        checks++; if (bus.cout !== ec[c-LAT]) begin failures++; $display("FAIL stream_cout op=%0d got=%0b exp=%0b", c-LAT, bus.cout, ec[c-LAT]); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_idle cycle=%0d got=%0b exp=0", c, bus.out_valid); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] va[6], vb[6], es[6];
    logic        vs[6], ec[6];
    int          in_idx, out_idx, stall_left;
    bit          acc, emit;
    va = '{32'h10, 32'h100, 32'hFFFF_FF00, 32'h1234_5678, 32'h8000_0000, 32'hA};
    vb = '{32'h01, 32'h200, 32'h0000_0100, 32'h1111_1111, 32'h8000_0000, 32'h3};
    vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    es = '{32'h11, 32'h300, 32'h0, 32'h2345_6789, 32'h0, 32'h7};
    ec = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    in_idx = 0; out_idx = 0; stall_left = -1;
    for (int c = 0; c < 40 && out_idx < 6; c++) begin
      if (in_idx < 6) drive_op(va[in_idx], vb[in_idx], 1'b0, vs[in_idx]);
      else drive_idle();
      if (stall_left < 0 && bus.out_valid === 1'b1) stall_left = 3;
      bus.out_ready = !(stall_left > 0);
      #1;
      if (stall_left > 0) begin
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%0b exp=0", c, bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cycle=%0d got=%0b exp=1", c, bus.out_valid); end
        checks++; if (bus.sum !== es[out_idx]) begin failures++; $display("FAIL bp_hold_sum cycle=%0d got=%h exp=%h", c, bus.sum, es[out_idx]); end
      end
      acc  = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
      emit = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
      if (emit) begin
        checks++; if (bus.sum !== es[out_idx]) begin failures++; $display("FAIL bp_sum op=%0d got=%h exp=%h", out_idx, bus.sum, es[out_idx]); end
        checks++; if (bus.cout !== ec[out_idx]) begin failures++; $display("FAIL bp_cout op=%0d got=%0b exp=%0b", out_idx, bus.cout, ec[out_idx]); end
      end
      tick();
      if (acc) in_idx++;
      if (emit) out_idx++;
      if (stall_left > 0) stall_left--;
    end
    bus.out_ready = 1'b1;
    drive_idle();
    checks++; if (out_idx != 6) begin failures++; $display("FAIL bp_emitted got=%0d exp=6", out_idx); end
    checks++; if (in_idx != 6) begin failures++; $display("FAIL bp_accepted got=%0d exp=6", in_idx); end
    checks++; if (stall_left != 0) begin failures++; $display("FAIL bp_stall_seen got=%0d exp=0", stall_left); end
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_duplicate cycle=%0d got=%0b exp=0", c, bus.out_valid); end
      tick();
    end
  endtask

  task automatic test_reset_mid_op();
    for (int c = 0; c < 4; c++) begin
      if (c < 3) drive_op(32'd2 * c + 1, 32'd2 * c + 2, 1'b0, 1'b0);
      else begin
        drive_idle();
        rst = 1'b1;
      end
      tick();
    end
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.sum !== 32'h0) begin failures++; $display("FAIL rst_mid_sum got=%h exp=00000000", bus.sum); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%0b exp=1", bus.in_ready); end
    for (int c = 0; c < 8; c++) begin
      if (c == 0) drive_op(32'h100, 32'h23, 1'b0, 1'b0);
      else drive_idle();
      #1;
      if (c == LAT) begin
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rst_new_valid got=%0b exp=1", bus.out_valid); end
        checks++; if (bus.sum !== 32'h123) begin failures++; $display("FAIL rst_new_sum got=%h exp=00000123", bus.sum); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_stale cycle=%0d got=%0b exp=0", c, bus.out_valid); end
      end
      tick();
    end
  endtask

`ifdef ADDSUB_OVF_EN
  task automatic test_ovf();
    logic [31:0] va[3], vb[3], es[3];
    logic        vs[3], ec[3], eo[3];
    va = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd3};
    vb = '{32'h1, 32'h1, 32'd4};
    vs = '{1'b0, 1'b1, 1'b0};
    es = '{32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
    ec = '{1'b0, 1'b1, 1'b0};
    eo = '{1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 8; c++) begin
      if (c < 3) drive_op(va[c], vb[c], 1'b0, vs[c]);
      else drive_idle();
      #1;
      if (c >= LAT && c < LAT + 3) begin
        checks++; if (bus.sum !== es[c-LAT]) begin failures++; $display("FAIL ovf_sum op=%0d got=%h exp=%h", c-LAT, bus.sum, es[c-LAT]); end
        checks++; if (bus.cout !== ec[c-LAT]) begin failures++; $display("FAIL ovf_cout op=%0d got=%0b exp=%0b", c-LAT, bus.cout, ec[c-LAT]); end
        checks++; if (bus.ovf !== eo[c-LAT]) begin failures++; $display("FAIL ovf_flag op=%0d got=%0b exp=%0b", c-LAT, bus.ovf, eo[c-LAT]); end
      end
      tick();
    end
  endtask
`endif

  initial begin
    bus.out_ready = 1'b1;
    drive_idle();
    test_reset();
    test_add_carry();
    test_sub_bubbles();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
`ifdef ADDSUB_OVF_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
